mips_alu: RTL and testbench

- 32-bit integer ALU for the multicycle MIPS datapath; sits between the A/B operand registers and the ALUOut register.
- Selects one of 13 operations via a 4-bit control code from ALU control.
- Registers the result and a zero flag with one-cycle latency; zero drives the branch (beq/bne) decision.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_shifter.sv | 25 ++
 rtl/mips_alu.sv | 121 ++++++++++++
 tb/tb_mips_alu.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the mips_alu slice: op-code encodings, shifter modes and a
// bit-reverse helper used to build the left shift out of the right-shift network.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND  = 4'd0;
    localparam alu_op_t ALU_OR   = 4'd1;
    localparam alu_op_t ALU_ADD  = 4'd2;
    localparam alu_op_t ALU_SLL  = 4'd3;
    localparam alu_op_t ALU_SRL  = 4'd4;
    localparam alu_op_t ALU_SRA  = 4'd5;
    localparam alu_op_t ALU_SUB  = 4'd6;
    localparam alu_op_t ALU_SLT  = 4'd7;
    localparam alu_op_t ALU_NOR  = 4'd8;
    localparam alu_op_t ALU_XOR  = 4'd9;
    localparam alu_op_t ALU_SLTU = 4'd10;
    localparam alu_op_t ALU_SLLV = 4'd11;
    localparam alu_op_t ALU_SRLV = 4'd12;

    typedef enum logic [1:0] {
        ShLeft,
        ShRightLogic,
        ShRightArith
    } shift_mode_t;

    function automatic logic [31:0] bit_reverse(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = d[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 5-stage barrel shifter. Left shifts reuse the right-shift stages by
// reversing the word on the way in and out.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [4:0]  amount,
    input  shift_mode_t mode,
    output logic [31:0] shifted
);

    logic        fill;
    logic [31:0] stage [0:5];

    assign fill     = (mode == ShRightArith) ? data[31] : 1'b0;
    assign stage[0] = (mode == ShLeft) ? bit_reverse(data) : data;

    for (genvar i = 0; i < 5; i++) begin : g_stage
        localparam int unsigned Sh = 1 << i;
        assign stage[i+1] = amount[i] ? {{Sh{fill}}, stage[i][31:Sh]} : stage[i];
    end

    assign shifted = (mode == ShLeft) ? bit_reverse(stage[5]) : stage[5];

endmodule

// File: rtl/mips_alu.sv
// Registered 32-bit ALU for the multicycle MIPS datapath; result and zero update one
// clock after operands are sampled. Define ALU_OVERFLOW_EN to add the registered ovf flag.
module mips_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       ALUCnt,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
`ifdef ALU_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             zero
);

    alu_op_t          op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sh_out;
    logic [4:0]       sh_amount;
    shift_mode_t      sh_mode;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    assign op   = alu_op_t'(ALUCnt);
    assign sum  = input1 + input2;
    assign diff = input1 - input2;

    // Variable shifts take their amount from rs; fixed shifts use the instruction field.
    always_comb begin
        sh_amount = shamt;
        sh_mode   = ShLeft;
        case (op)
            ALU_SLLV: begin
                sh_amount = input1[4:0];
                sh_mode   = ShLeft;
            end
            ALU_SRLV: begin
                sh_amount = input1[4:0];
                sh_mode   = ShRightLogic;
            end
            ALU_SRL:  sh_mode = ShRightLogic;
            ALU_SRA:  sh_mode = ShRightArith;
            default:  sh_mode = ShLeft;
        endcase
    end

    alu_shifter u_shifter (
        .data    (input2),
        .amount  (sh_amount),
        .mode    (sh_mode),
        .shifted (sh_out)
    );

    always_comb begin
        result_d = '0;
        case (op)
            ALU_AND:  result_d = input1 & input2;
            ALU_OR:   result_d = input1 | input2;
            ALU_ADD:  result_d = sum;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA,
            ALU_SLLV,
            ALU_SRLV: result_d = sh_out;
            ALU_SUB:  result_d = diff;
            ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            ALU_NOR:  result_d = ~(input1 | input2);
            ALU_XOR:  result_d = input1 ^ input2;
            ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, (input1 < input2)};
            default:  result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= (result_d == '0);
        end
    end

    assign result = result_q;
    assign zero   = zero_q;

`ifdef ALU_OVERFLOW_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result flips.
    always_comb begin
        ovf_d = 1'b0;
        case (op)
            ALU_ADD: ovf_d = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                             (sum[WIDTH-1] != input1[WIDTH-1]);
            ALU_SUB: ovf_d = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                             (diff[WIDTH-1] != input1[WIDTH-1]);
            default: ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed vectors plus a random sweep, with expected
// values queued at drive time and popped one edge later.
module tb_mips_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ALUCnt;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
`ifdef ALU_OVERFLOW_EN
    logic        ovf;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } vec_t;

    exp_t sb[$];

    mips_alu #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ALUCnt (ALUCnt),
        .input1 (input1),
        .input2 (input2),
        .shamt  (shamt),
        .result (result),
`ifdef ALU_OVERFLOW_EN
        .ovf    (ovf),
`endif
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t        e;
        logic [32:0] wide;
        logic [31:0] r;
        r    = 32'h0;
        wide = 33'h0;
        e.ovf = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                wide  = {a[31], a} + {b[31], b};
                r     = wide[31:0];
                e.ovf = wide[32] ^ wide[31];
            end
            4'd3:  r = b << sh;
            4'd4:  r = b >> sh;
            4'd5:  r = $signed(b) >>> sh;
            4'd6: begin
                wide  = {a[31], a} - {b[31], b};
                r     = wide[31:0];
                e.ovf = wide[32] ^ wide[31];
            end
            4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  r = ~(a | b);
            4'd9:  r = a ^ b;
            4'd10: r = (a < b) ? 32'd1 : 32'd0;
            4'd11: r = b << a[4:0];
            4'd12: r = b >> a[4:0];
            default: r = 32'h0;
        endcase
        e.res  = r;
        e.zero = (r == 32'h0);
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        ALUCnt = op;
        input1 = a;
        input2 = b;
        shamt  = sh;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));
            sb.push_back('{res: 32'h0, zero: 1'b1, ovf: 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (result !== e.res || zero !== e.zero) begin
                errors++;
                $display("FAIL reset[%0d]: result=%h zero=%b, expected %h %b",
                         i, result, zero, e.res, e.zero);
            end
`ifdef ALU_OVERFLOW_EN
            checks++;
            if (ovf !== e.ovf) begin
                errors++;
                $display("FAIL reset_ovf[%0d]: ovf=%b expected %b", i, ovf, e.ovf);
            end
`endif
        end
        rst_n = 1'b1;
        drive(4'd2, 32'd1, 32'd2, 5'd0);
        sb.push_back('{res: 32'd3, zero: 1'b0, ovf: 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (result !== e.res || zero !== e.zero) begin
            errors++;
            $display("FAIL first_after_reset: result=%h zero=%b, expected %h %b",
                     result, zero, e.res, e.zero);
        end
    endtask

    task automatic test_directed(input string name, input vec_t v[]);
        exp_t e;
        foreach (v[i]) begin
            drive(v[i].op, v[i].a, v[i].b, v[i].sh);
            sb.push_back('{res: v[i].res, zero: v[i].zero, ovf: v[i].ovf});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (result !== e.res || zero !== e.zero) begin
                errors++;
                $display("FAIL %s[%0d] op=%0d: result=%h zero=%b, expected %h %b",
                         name, i, v[i].op, result, zero, e.res, e.zero);
            end
`ifdef ALU_OVERFLOW_EN
            checks++;
            if (ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s_ovf[%0d]: ovf=%b expected %b", name, i, ovf, e.ovf);
            end
`endif
        end
    endtask

    task automatic test_arith();
        vec_t v[] = '{
            '{4'd2, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b1},
            '{4'd2, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b0},
            '{4'd6, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 1'b1, 1'b0},
            '{4'd6, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1}
        };
        test_directed("arith", v);
    endtask

    task automatic test_compare();
        vec_t v[] = '{
            '{4'd7,  32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0},
            '{4'd10, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b0},
            '{4'd7,  32'h12345678, 32'h12345678, 5'd0, 32'h00000000, 1'b1, 1'b0},
            '{4'd10, 32'h12345678, 32'h12345678, 5'd0, 32'h00000000, 1'b1, 1'b0}
        };
        test_directed("compare", v);
    endtask

    task automatic test_shift();
        vec_t v[] = '{
            '{4'd3,  32'h00000000, 32'h00000003, 5'd2,  32'h0000000C, 1'b0, 1'b0},
            '{4'd4,  32'h00000000, 32'h80000000, 5'd2,  32'h20000000, 1'b0, 1'b0},
            '{4'd5,  32'h00000000, 32'h80000000, 5'd2,  32'hE0000000, 1'b0, 1'b0},
            '{4'd11, 32'h00000024, 32'h00000001, 5'd2,  32'h00000010, 1'b0, 1'b0},
            '{4'd12, 32'h0000001F, 32'h80000000, 5'd0,  32'h00000001, 1'b0, 1'b0},
            '{4'd3,  32'h00000000, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0},
            '{4'd5,  32'h00000000, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0},
            '{4'd3,  32'h00000000, 32'h00000003, 5'd31, 32'h80000000, 1'b0, 1'b0}
        };
        test_directed("shift", v);
    endtask

    task automatic test_logic();
        vec_t v[] = '{
            '{4'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 1'b0, 1'b0},
            '{4'd1, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFFF0FFF0, 1'b0, 1'b0},
            '{4'd9, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFF00FF00, 1'b0, 1'b0},
            '{4'd8, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h000F000F, 1'b0, 1'b0}
        };
        test_directed("logic", v);
    endtask

    // Two cycles per code; a one-cycle reset pulse lands inside the SLT slot.
    task automatic test_sweep();
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        for (int code = 0; code < 16; code++) begin
            for (int k = 0; k < 2; k++) begin
                a  = $urandom;
                b  = $urandom;
                sh = 5'($urandom_range(0, 31));
                drive(4'(code), a, b, sh);
                rst_n = !(code == 7 && k == 0);
                if (!rst_n) sb.push_back('{res: 32'h0, zero: 1'b1, ovf: 1'b0});
                else        sb.push_back(model(4'(code), a, b, sh));
                @(posedge clk); #1;
                e = sb.pop_front();
                checks++;
                if (result !== e.res || zero !== e.zero) begin
                    errors++;
                    $display("FAIL sweep code=%0d k=%0d rst_n=%b: result=%h zero=%b, expected %h %b",
                             code, k, rst_n, result, zero, e.res, e.zero);
                end
`ifdef ALU_OVERFLOW_EN
                checks++;
                if (ovf !== e.ovf) begin
                    errors++;
                    $display("FAIL sweep_ovf code=%0d: ovf=%b expected %b", code, ovf, e.ovf);
                end
`endif
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = (i % 5 == 0) ? 32'h80000000 : $urandom;
            b  = (i % 7 == 0) ? a : $urandom;
            sh = 5'($urandom_range(0, 31));
            drive(op, a, b, sh);
            sb.push_back(model(op, a, b, sh));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (result !== e.res || zero !== e.zero) begin
                errors++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h sh=%0d: result=%h zero=%b, expected %h %b",
                         i, op, a, b, sh, result, zero, e.res, e.zero);
            end
`ifdef ALU_OVERFLOW_EN
            checks++;
            if (ovf !== e.ovf) begin
                errors++;
                $display("FAIL b2b_ovf[%0d]: ovf=%b expected %b", i, ovf, e.ovf);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'd0, 32'h0, 32'h0, 5'd0);
        #1;
        test_reset();
        test_arith();
        test_compare();
        test_shift();
        test_logic();
        test_sweep();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
